seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Read-back end of the dice display path: samples the active-low 7-segment bus that drives the display and recovers the BCD digit.
- The block requires the pattern to be stable for a programmable number of cycles before decoding it (debounce/glitch filter).
- It then presents the recovered digit on a valid/ready handshake, flagging blank and illegal patterns.
- Used for self-check of the dice display and as a loop-back monitor in simulation and on board.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles a sampled pattern must stay unchanged before it is reported; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- seg  input  7  segment bus, seg[6]=a … seg[0]=g, 0 = segment lit
- ready  input  1  consumer accepts the current report when high with valid
- valid  output  1  report available; held until accepted
- digit  output  4  recovered BCD digit 0..9; 4'hF when blank; 4'h0 when err
- blank  output  1  reported pattern was all segments off (7'b1111111)
- err  output  1  reported pattern is not a legal digit or blank
- err_cnt  output  8  count of accepted err reports, saturates at 255

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state changes occur on the rising edge of clk.
- Input stage:
  - seg_q <= seg; seg_prev <= seg_q.
  - seg_q/seg_prev compare decides stability.
  - No combinational path from seg to any output.
- Legal patterns (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank = 1111111; every other pattern is err.
- Reset (rst_n=0 at an edge): state=SETTLE, stable_cnt=0, seg_q=seg_prev=7'b1111111, valid=0, digit=0, blank=0, err=0, err_cnt=0.
  - Reset mid-report discards the pending report without a handshake.
- FSM states: SETTLE, REPORT, HOLD.
- SETTLE:
  - If seg_q!=seg_prev, then stable_cnt<=0.
  - Otherwise stable_cnt increments, saturating at 8 bits.
  - On the edge where the increment reaches STABLE_CYCLES: latch seg_q into pat_l, latch the decode into digit/blank/err, set valid=1, go to REPORT.
- Latency: if the edge that first samples pattern P into seg_q is edge E, and seg then holds P, valid rises at edge E+STABLE_CYCLES+1.
- REPORT:
  - valid, digit, blank and err are held constant regardless of seg activity.
  - When valid&&ready at an edge: valid<=0, go to HOLD. If err=1, err_cnt increments, saturating at 255.
  - ready is ignored while valid=0.
- HOLD:
  - Stays in HOLD while seg_q==pat_l, so one stable pattern yields exactly one report.
  - When seg_q!=pat_l: stable_cnt<=0, go to SETTLE.
  - If the pattern already changed during REPORT, HOLD lasts exactly one cycle.
- Glitches: any pulse shorter than STABLE_CYCLES+1 cycles produces no report.
- Outputs after acceptance: digit, blank and err keep their last values while valid=0.

Decomposition:
- Package seg7_pkg holds:
  - localparams SEG_0..SEG_9 and SEG_BLANK (7-bit active-low codes above);
  - DIGIT_BLANK=4'hF;
  - state encodings ST_SETTLE=2'd0, ST_REPORT=2'd1, ST_HOLD=2'd2.
- The decoder is also the natural source for these constants.
- One sub-module, seg7_encode: purely combinational seg[6:0] -> {digit[3:0], blank, err}, instantiated once on seg_q.
- FSM, counter, handshake and err_cnt stay in seg7_reader.

Test Plan:
- Reset then seg=7'b0010010 held, STABLE_CYCLES=4, ready=1 -> valid high for one cycle at edge E+5, digit=2, blank=0, err=0; no second report while seg is unchanged.
- Sweep all ten legal codes, each held 10 cycles, ready=1 -> ten reports in order with digit 0..9; err_cnt stays 0.
- seg=7'b1111111 held -> blank=1, digit=4'hF, err=0. seg=7'b1111110 held -> err=1, digit=0; after ready, err_cnt=1. 300 such err reports -> err_cnt=255.
- seg=7'b1001111 held 3 cycles, then 7'b0000110 held: with STABLE_CYCLES=4 only digit=3 is reported. With STABLE_CYCLES=1, digit=1 is reported, then digit=3.
- ready=0 while valid: digit=5 held for 20 cycles while seg changes to 7 -> valid and digit=5 held. After ready pulses, digit=7 is reported STABLE_CYCLES+1 cycles later or sooner, never dropped.
- rst_n=0 for one cycle while in REPORT with digit=8 -> next cycle valid=0, err_cnt=0, digit=0. Holding seg=8 then produces a fresh report at edge E+5.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment read-back path: active-low segment codes
// (a..g, MSB = a), the blank digit code and the reader FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_REPORT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational decode of an active-low segment pattern into a BCD digit,
// with flags for the all-off (blank) pattern and for anything unrecognised.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    digit = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (seg)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: begin
        digit = DIGIT_BLANK;
        blank = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples the active-low 7-segment bus, waits for a pattern to stay stable,
// and reports the decoded digit once per stable pattern on a valid/ready handshake.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

  state_t     state;
  logic [6:0] seg_q;
  logic [6:0] seg_prev;
  logic [6:0] pat_l;
  logic [7:0] stable_cnt;
  logic [7:0] cnt_inc;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_err;

  seg7_encode u_encode (
    .seg   (seg_q),
    .digit (dec_digit),
    .blank (dec_blank),
    .err   (dec_err)
  );

  assign cnt_inc = (stable_cnt == 8'hFF) ? stable_cnt : stable_cnt + 8'd1;

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_SETTLE;
      stable_cnt <= 8'd0;
      seg_q      <= SEG_BLANK;
      seg_prev   <= SEG_BLANK;
      pat_l      <= SEG_BLANK;
      valid      <= 1'b0;
      digit      <= 4'd0;
      blank      <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      seg_q    <= seg;
      seg_prev <= seg_q;
      case (state)
        ST_SETTLE: begin
          if (seg_q != seg_prev) begin
            stable_cnt <= 8'd0;
          end else begin
            stable_cnt <= cnt_inc;
            if (cnt_inc == STABLE_TGT) begin
              pat_l <= seg_q;
              digit <= dec_digit;
              blank <= dec_blank;
              err   <= dec_err;
              valid <= 1'b1;
              state <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          if (ready) begin
            valid <= 1'b0;
            state <= ST_HOLD;
            if (err && (err_cnt != 8'hFF)) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        ST_HOLD: begin
          // Re-arm only once the bus moves away from the pattern just reported.
          if (seg_q != pat_l) begin
            stable_cnt <= 8'd0;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: one instance with STABLE_CYCLES=4, one with 1,
// sharing stimulus; accepted reports are logged per instance and compared to hand-derived values.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       ready;

  logic       valid, blank, err;
  logic [3:0] digit;
  logic [7:0] err_cnt;
  logic       valid1, blank1, err1;
  logic [3:0] digit1;
  logic [7:0] err_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Accepted reports, packed as {blank, err, digit}.
  logic [5:0] q4[$];
  logic [5:0] q1[$];

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .ready(ready),
    .valid(valid), .digit(digit), .blank(blank), .err(err), .err_cnt(err_cnt)
  );

  seg7_reader #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg), .ready(ready),
    .valid(valid1), .digit(digit1), .blank(blank1), .err(err1), .err_cnt(err_cnt1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && ready)   q4.push_back({blank, err, digit});
    if (valid1 && ready)  q1.push_back({blank1, err1, digit1});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010,
                         P3 = 7'b0000110, P4 = 7'b1001100, P5 = 7'b0100100,
                         P6 = 7'b0100000, P7 = 7'b0001111, P8 = 7'b0000000,
                         P9 = 7'b0000100, PBLANK = 7'b1111111;
  localparam logic [6:0] PERR_A = 7'b1111110, PERR_B = 7'b0111111;

  initial begin
    logic [6:0] codes [10];
    int         bad;
    bit         found;
    codes = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};

    // Reset, then digit 2 held: valid rises at E+5 with E the first released edge.
    rst_n = 1'b0;
    seg   = P2;
    ready = 1'b1;
    step(2);
    check("rst_valid", valid, 1'b0);
    check("rst_digit", digit, 4'd0);
    check("rst_blank", blank, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    q4.delete();
    rst_n = 1'b1;
    step(1);
    step(4);
    check("d2_not_yet", valid, 1'b0);
    step(1);
    check("d2_valid", valid, 1'b1);
    check("d2_digit", digit, 4'd2);
    check("d2_blank", blank, 1'b0);
    check("d2_err", err, 1'b0);
    step(1);
    check("d2_dropped", valid, 1'b0);
    step(10);
    check("d2_one_report", q4.size(), 1);

    // Sweep all legal codes.
    q4.delete();
    for (int i = 0; i < 10; i++) begin
      seg = codes[i];
      step(10);
    end
    check("sweep_count", q4.size(), 10);
    for (int i = 0; i < 10 && i < q4.size(); i++) begin
      check($sformatf("sweep_%0d", i), q4[i], {2'b00, 4'(i)});
    end
    check("sweep_err_cnt", err_cnt, 8'd0);

    // Blank then an illegal pattern.
    q4.delete();
    seg = PBLANK;
    step(10);
    check("blank_count", q4.size(), 1);
    if (q4.size() > 0) check("blank_report", q4[0], 6'b10_1111);
    check("blank_held_digit", digit, 4'hF);
    check("blank_held_flag", blank, 1'b1);
    check("blank_idle", valid, 1'b0);
    q4.delete();
    seg = PERR_A;
    step(10);
    check("err_count", q4.size(), 1);
    if (q4.size() > 0) check("err_report", q4[0], 6'b01_0000);
    check("err_cnt_1", err_cnt, 8'd1);
    for (int i = 0; i < 253; i++) begin
      seg = (i % 2 == 0) ? PERR_B : PERR_A;
      step(8);
    end
    check("err_cnt_254", err_cnt, 8'd254);
    seg = PERR_A;
    step(8);
    check("err_cnt_255", err_cnt, 8'd255);
    for (int i = 0; i < 45; i++) begin
      seg = (i % 2 == 0) ? PERR_B : PERR_A;
      step(8);
    end
    check("err_cnt_sat", err_cnt, 8'd255);

    // Short pulse of 1 (3 cycles) followed by 3.
    q4.delete();
    q1.delete();
    seg = P1;
    step(3);
    seg = P3;
    step(12);
    check("glitch4_count", q4.size(), 1);
    if (q4.size() > 0) check("glitch4_digit", q4[0], 6'd3);
    check("glitch1_count", q1.size(), 2);
    if (q1.size() > 1) begin
      check("glitch1_first", q1[0], 6'd1);
      check("glitch1_second", q1[1], 6'd3);
    end

    // Backpressure: 5 is held while the bus moves on to 7.
    q4.delete();
    ready = 1'b0;
    seg = P5;
    step(6);
    check("bp_valid", valid, 1'b1);
    check("bp_digit", digit, 4'd5);
    seg = P7;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!(valid === 1'b1 && digit === 4'd5)) bad++;
    end
    check("bp_held_cycles_bad", bad, 0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    check("bp_accept", valid, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      step(1);
      if (valid) found = 1'b1;
    end
    check("bp_d7_seen", found, 1'b1);
    check("bp_d7_digit", digit, 4'd7);
    ready = 1'b1;
    step(2);
    check("bp_reports", q4.size(), 2);
    if (q4.size() > 1) begin
      check("bp_first", q4[0], 6'd5);
      check("bp_second", q4[1], 6'd7);
    end

    // Reset during a pending report of 8.
    ready = 1'b0;
    seg = P8;
    step(6);
    check("r8_valid", valid, 1'b1);
    check("r8_digit", digit, 4'd8);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("r8_rst_valid", valid, 1'b0);
    check("r8_rst_err_cnt", err_cnt, 8'd0);
    check("r8_rst_digit", digit, 4'd0);
    step(5);
    check("r8_not_yet", valid, 1'b0);
    step(1);
    check("r8_fresh_valid", valid, 1'b1);
    check("r8_fresh_digit", digit, 4'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
